// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_scheduler
//  Description : Buffers up to two committed branch outcomes per cycle and
//                replays them to the branch predictor one per cycle, in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             commit0_valid,
    input  logic [31:0]      commit0_PC,
    input  logic             commit0_taken,
    input  logic             commit1_valid,
    input  logic [31:0]      commit1_PC,
    input  logic             commit1_taken,
    input  logic             drain_in,
    output logic             stall_out,
    output logic             idle_out,
    output logic [PTR_W:0]   count_out,
    output logic             update_en,
    output logic [31:0]      update_PC,
    output logic             update_result
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Two free slots are needed to take a dual commit, so stall above DEPTH-2.
    localparam logic [PTR_W:0] c_stall_lvl = (PTR_W + 1)'(DEPTH - 2);

    state_t             r_state_q;
    state_t             w_state_d;
    logic [PTR_W-1:0]   r_head_q;
    logic [PTR_W-1:0]   w_head_d;
    logic [PTR_W-1:0]   r_tail_q;
    logic [PTR_W-1:0]   w_tail_d;
    logic [PTR_W:0]     r_count_q;
    logic [PTR_W:0]     w_count_d;
    logic               r_upd_en_q;
    logic               w_upd_en_d;
    logic [31:0]        r_upd_pc_q;
    logic [31:0]        w_upd_pc_d;
    logic               r_upd_res_q;
    logic               w_upd_res_d;

    // Entry layout: {PC, taken}
    logic [32:0]        r_mem_q [DEPTH];

    logic               w_stall;
    logic               w_accept;
    logic               w_deq;
    logic [1:0]         w_enq_num;
    logic               w_wr0_en;
    logic               w_wr1_en;
    logic [PTR_W-1:0]   w_wr0_idx;
    logic [PTR_W-1:0]   w_wr1_idx;
    logic [32:0]        w_wr0_data;
    logic [32:0]        w_wr1_data;
    logic [32:0]        w_head_entry;

    assign w_stall      = (r_count_q > c_stall_lvl) || (r_state_q != ST_RUN);
    assign w_accept     = rdy_in && !w_stall;
    assign w_deq        = rdy_in && (r_count_q != '0);
    assign w_head_entry = r_mem_q[r_head_q];
    assign w_wr0_idx    = r_tail_q;
    assign w_wr1_idx    = r_tail_q + PTR_W'(1);

    // Enqueue: a lone valid commit (from either slot) always lands at tail.
    always_comb begin
        w_wr0_en   = 1'b0;
        w_wr1_en   = 1'b0;
        w_wr0_data = {commit0_PC, commit0_taken};
        w_wr1_data = {commit1_PC, commit1_taken};
        w_enq_num  = 2'd0;
        if (w_accept) begin
            if (commit0_valid && commit1_valid) begin
                w_wr0_en  = 1'b1;
                w_wr1_en  = 1'b1;
                w_enq_num = 2'd2;
            end else if (commit0_valid) begin
                w_wr0_en  = 1'b1;
                w_enq_num = 2'd1;
            end else if (commit1_valid) begin
                w_wr0_en   = 1'b1;
                w_wr0_data = {commit1_PC, commit1_taken};
                w_enq_num  = 2'd1;
            end
        end
    end

    always_comb begin
        w_tail_d    = r_tail_q + PTR_W'(w_enq_num);
        w_head_d    = r_head_q;
        w_upd_en_d  = r_upd_en_q;
        w_upd_pc_d  = r_upd_pc_q;
        w_upd_res_d = r_upd_res_q;
        if (w_deq) begin
            w_upd_en_d  = 1'b1;
            w_upd_pc_d  = w_head_entry[32:1];
            w_upd_res_d = w_head_entry[0];
            w_head_d    = r_head_q + PTR_W'(1);
        end else if (rdy_in) begin
            w_upd_en_d  = 1'b0;
        end
        w_count_d = r_count_q + (PTR_W + 1)'(w_enq_num) - (PTR_W + 1)'(w_deq);
    end

    always_comb begin
        w_state_d = r_state_q;
        if (rdy_in) begin
            case (r_state_q)
                ST_RUN: begin
                    if (drain_in) w_state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_count_q == '0) w_state_d = drain_in ? ST_IDLE : ST_RUN;
                    else if (!drain_in)  w_state_d = ST_RUN;
                end
                ST_IDLE: begin
                    if (!drain_in) w_state_d = ST_RUN;
                end
                default: w_state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state_q   <= ST_RUN;
            r_head_q    <= '0;
            r_tail_q    <= '0;
            r_count_q   <= '0;
            r_upd_en_q  <= 1'b0;
            r_upd_pc_q  <= '0;
            r_upd_res_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_head_q    <= w_head_d;
            r_tail_q    <= w_tail_d;
            r_count_q   <= w_count_d;
            r_upd_en_q  <= w_upd_en_d;
            r_upd_pc_q  <= w_upd_pc_d;
            r_upd_res_q <= w_upd_res_d;
        end
    end

    // Storage is not reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && w_wr0_en) r_mem_q[w_wr0_idx] <= w_wr0_data;
        if (rst_n_in && w_wr1_en) r_mem_q[w_wr1_idx] <= w_wr1_data;
    end

    assign stall_out     = w_stall;
    assign idle_out      = (r_state_q == ST_IDLE);
    assign count_out     = r_count_q;
    assign update_en     = r_upd_en_q;
    assign update_PC     = r_upd_pc_q;
    assign update_result = r_upd_res_q;

endmodule
`default_nettype wire
